// File: rtl/counter_pkg.sv
// counter_pkg: shared direction and boundary-mode constants for the up/down counter.
package counter_pkg;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/updown_counter_n_if.sv
// updown_counter_n_if: control inputs and count/flag outputs of the up/down counter.
interface updown_counter_n_if #(parameter int WIDTH = 16);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic             sat_mode;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             borrow;
    logic             carry;
    logic             sat;
    modport master (output en, load, load_val, dir, sat_mode,
                    input  count, zero, borrow, carry, sat);
    modport slave  (input  en, load, load_val, dir, sat_mode,
                    output count, zero, borrow, carry, sat);
endinterface

// File: rtl/fullAdder.sv
// fullAdder: one-bit full adder cell of the incdec ripple.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/incdec_n.sv
// incdec_n: combinational a +/- 1 as a ripple of fullAdder cells.
// Decrement adds all-ones with cin=0, increment adds zero with cin=1.
module incdec_n import counter_pkg::*; #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] a,
    input  logic             dir,
    output logic [WIDTH-1:0] y,
    output logic             cout
);
    logic [WIDTH:0] c;
    assign c[0] = (dir == DIR_UP);
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        fullAdder fa (.a(a[i]), .b(dir == DIR_DOWN), .ci(c[i]), .s(y[i]), .co(c[i+1]));
    end
    assign cout = c[WIDTH];
endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: loadable up/down counter with wrap or saturate at the range ends
// and registered borrow/carry/sat pulses aligned with the new count.
module updown_counter_n import counter_pkg::*; #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                clk,
    input logic                rst,
    updown_counter_n_if.slave  bus
);
    logic [WIDTH-1:0] stepVal;
    logic             cout;
    logic             atEnd;
    incdec_n #(.WIDTH(WIDTH)) u_incdec (.a(bus.count), .dir(bus.dir), .y(stepVal), .cout(cout));
    // Down wraps when no carry out of the all-ones add; up wraps on carry out.
    assign atEnd    = (bus.dir == DIR_UP) ? cout : ~cout;
    assign bus.zero = (bus.count == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.count  <= RESET_VAL;
            bus.borrow <= 1'b0;
            bus.carry  <= 1'b0;
            bus.sat    <= 1'b0;
        end else if (bus.load) begin
            bus.count  <= bus.load_val;
            bus.borrow <= 1'b0;
            bus.carry  <= 1'b0;
            bus.sat    <= 1'b0;
        end else if (bus.en) begin
            bus.count  <= (atEnd && bus.sat_mode == MODE_SAT) ? bus.count : stepVal;
            bus.borrow <= atEnd && bus.sat_mode == MODE_WRAP && bus.dir == DIR_DOWN;
            bus.carry  <= atEnd && bus.sat_mode == MODE_WRAP && bus.dir == DIR_UP;
            bus.sat    <= atEnd && bus.sat_mode == MODE_SAT;
        end else begin
            bus.borrow <= 1'b0;
            bus.carry  <= 1'b0;
            bus.sat    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: directed scoreboard bench over 16-, 4- and 32-bit counters.
module tb_updown_counter_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    updown_counter_n_if #(.WIDTH(16)) a();
    updown_counter_n_if #(.WIDTH(4))  b();
    updown_counter_n_if #(.WIDTH(32)) c();

    updown_counter_n #(.WIDTH(16), .RESET_VAL(16'h0005)) u16 (.clk(clk), .rst(rst), .bus(a));
    updown_counter_n #(.WIDTH(4),  .RESET_VAL(4'h0))     u4  (.clk(clk), .rst(rst), .bus(b));
    updown_counter_n #(.WIDTH(32), .RESET_VAL(32'h0))    u32 (.clk(clk), .rst(rst), .bus(c));

    typedef struct {
        int          id;
        logic [31:0] cnt;
        logic [3:0]  flags;
        string       tag;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total  = 0;

    task automatic push(input int id, input logic [31:0] cnt, input logic bo, input logic ca,
                        input logic sa, input string tag);
        exp_t e;
        e.id = id;
        e.cnt = cnt;
        e.flags = {cnt == 32'h0, bo, ca, sa};
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic checkAll();
        exp_t e;
        logic [31:0] oc;
        logic [3:0]  of;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.id)
                0:       begin oc = 32'(a.count); of = {a.zero, a.borrow, a.carry, a.sat}; end
                1:       begin oc = 32'(b.count); of = {b.zero, b.borrow, b.carry, b.sat}; end
                default: begin oc = c.count;      of = {c.zero, c.borrow, c.carry, c.sat}; end
            endcase
            total++;
            assert (oc === e.cnt) passed++;
            else $error("FAIL %s count: got %h want %h", e.tag, oc, e.cnt);
            total++;
            assert (of === e.flags) passed++;
            else $error("FAIL %s zero/borrow/carry/sat: got %b want %b", e.tag, of, e.flags);
        end
    endtask

    task automatic drive(input int id, input logic en, input logic ld, input logic [31:0] lv,
                         input logic dr, input logic sm);
        case (id)
            0:       begin a.en = en; a.load = ld; a.load_val = lv[15:0]; a.dir = dr; a.sat_mode = sm; end
            1:       begin b.en = en; b.load = ld; b.load_val = lv[3:0];  b.dir = dr; b.sat_mode = sm; end
            default: begin c.en = en; c.load = ld; c.load_val = lv;       c.dir = dr; c.sat_mode = sm; end
        endcase
    endtask

    task automatic step(input int id, input logic en, input logic ld, input logic [31:0] lv,
                        input logic dr, input logic sm, input logic [31:0] cnt,
                        input logic bo, input logic ca, input logic sa, input string tag);
        drive(id, en, ld, lv, dr, sm);
        push(id, cnt, bo, ca, sa, tag);
        @(posedge clk);
        #1;
        checkAll();
        drive(id, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        rst = 1'b1;
        #1;
        push(0, 32'h5, 0, 0, 0, "rst_async16");
        push(1, 32'h0, 0, 0, 0, "rst_async4");
        push(2, 32'h0, 0, 0, 0, "rst_async32");
        checkAll();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 32'h5, 0, 0, 0, "hold");

        step(0, 0, 1, 32'h0002, 0, 0, 32'h0002, 0, 0, 0, "load2");
        step(0, 1, 0, 0, 0, 0, 32'h0001, 0, 0, 0, "dn1");
        step(0, 1, 0, 0, 0, 0, 32'h0000, 0, 0, 0, "dn0");
        step(0, 1, 0, 0, 0, 0, 32'hFFFF, 1, 0, 0, "dnwrap");
        step(0, 1, 0, 0, 0, 0, 32'hFFFE, 0, 0, 0, "dnpost");

        step(0, 0, 1, 32'h0001, 0, 1, 32'h0001, 0, 0, 0, "load1");
        step(0, 1, 0, 0, 0, 1, 32'h0000, 0, 0, 0, "satdn0");
        step(0, 1, 0, 0, 0, 1, 32'h0000, 0, 0, 1, "satdn1");
        step(0, 1, 0, 0, 0, 1, 32'h0000, 0, 0, 1, "satdn2");

        step(0, 0, 1, 32'hFFFE, 1, 0, 32'hFFFE, 0, 0, 0, "loadFFFE");
        step(0, 1, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, "up1");
        step(0, 1, 0, 0, 1, 0, 32'h0000, 0, 1, 0, "upwrap");
        step(0, 1, 0, 0, 1, 0, 32'h0001, 0, 0, 0, "uppost");

        step(0, 0, 1, 32'hFFFE, 1, 1, 32'hFFFE, 0, 0, 0, "loadFFFE2");
        step(0, 1, 0, 0, 1, 1, 32'hFFFF, 0, 0, 0, "satup1");
        step(0, 1, 0, 0, 1, 1, 32'hFFFF, 0, 0, 1, "satup2");
        step(0, 1, 0, 0, 1, 1, 32'hFFFF, 0, 0, 1, "satup3");
        step(0, 0, 0, 0, 1, 1, 32'hFFFF, 0, 0, 0, "holdclr");
        step(0, 1, 0, 0, 0, 1, 32'hFFFE, 0, 0, 0, "satleave");

        step(0, 1, 1, 32'h1234, 0, 0, 32'h1234, 0, 0, 0, "loadprio");
        step(0, 1, 0, 0, 0, 0, 32'h1233, 0, 0, 0, "dn1233");
        step(0, 1, 0, 0, 0, 0, 32'h1232, 0, 0, 0, "dn1232");
        drive(0, 1, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        push(0, 32'h5, 0, 0, 0, "rst_mid");
        checkAll();
        step(0, 1, 0, 0, 0, 0, 32'h5, 0, 0, 0, "rst_held");
        rst = 1'b0;
        step(0, 1, 0, 0, 0, 0, 32'h4, 0, 0, 0, "postrst");

        step(1, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0, 0, "w4load0");
        step(1, 1, 0, 0, 0, 0, 32'hF, 1, 0, 0, "w4dnwrap");
        step(1, 1, 0, 0, 1, 0, 32'h0, 0, 1, 0, "w4upwrap");

        step(2, 0, 1, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0, 0, "w32load");
        step(2, 1, 0, 0, 1, 0, 32'h00000000, 0, 1, 0, "w32upwrap");
        step(2, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, "w32dnwrap");
        step(2, 1, 0, 0, 0, 1, 32'hFFFFFFFE, 0, 0, 0, "w32dn");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
